// File: rtl/debug_dump_tx_if.sv
// Debug-dump side bus: start/PC from the core, register/memory debug read ports and the UART byte handshake.
// master = dump engine, slave = core/UART environment.
interface debug_dump_tx_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int ADDR_WIDTH      = 5
);
  logic                       i_start;
  logic [DATA_WIDTH-1:0]      i_pc;
  logic [ADDR_WIDTH-1:0]      o_reg_addr;
  logic [DATA_WIDTH-1:0]      i_reg_data;
  logic [ADDR_WIDTH-1:0]      o_mem_addr;
  logic [DATA_WIDTH-1:0]      i_mem_data;
  logic [DATA_WIDTH_UART-1:0] o_tx_byte;
  logic                       o_tx_signal;
  logic                       i_tx_done;
  logic                       o_busy;
  logic                       o_dump_done;

  modport master (
    input  i_start, i_pc, i_reg_data, i_mem_data, i_tx_done,
    output o_reg_addr, o_mem_addr, o_tx_byte, o_tx_signal, o_busy, o_dump_done
  );

  modport slave (
    output i_start, i_pc, i_reg_data, i_mem_data, i_tx_done,
    input  o_reg_addr, o_mem_addr, o_tx_byte, o_tx_signal, o_busy, o_dump_done
  );
endinterface

// File: rtl/debug_dump_tx.sv
// Dumps PC, N_REGS registers and N_MEM memory words to the UART as LSB-first bytes.
// First byte 1 cycle after start; paced by i_tx_done (1 cycle within a word, 3 across words).
module debug_dump_tx #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int N_REGS          = 32,
  parameter int N_MEM           = 32,
  parameter int ADDR_WIDTH      = 5
) (
  input logic             i_clock,
  input logic             i_reset,
  debug_dump_tx_if.master bus
);
  localparam int BYTES_PER_WORD = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef logic [ADDR_WIDTH:0] idx_t;
  typedef logic [BCNT_W-1:0]   bcnt_t;

  localparam bcnt_t LAST_BYTE = bcnt_t'(BYTES_PER_WORD - 1);
  localparam idx_t  REG_END   = idx_t'(N_REGS);
  localparam idx_t  MEM_END   = idx_t'(N_MEM);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPTURE, S_SEND, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {PH_PC, PH_REG, PH_MEM} phase_t;

  state_t                     state_q, state_d;
  phase_t                     phase_q, phase_d;
  logic [DATA_WIDTH-1:0]      shift_q, shift_d;
  bcnt_t                      bcnt_q, bcnt_d;
  idx_t                       idx_q, idx_d, idx_inc;
  logic [ADDR_WIDTH-1:0]      reg_addr_q, reg_addr_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH_UART-1:0] tx_byte_q, tx_byte_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_PC;
      shift_q    <= '0;
      bcnt_q     <= '0;
      idx_q      <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      shift_q    <= shift_d;
      bcnt_q     <= bcnt_d;
      idx_q      <= idx_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    idx_d      = idx_q;
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;
    tx_byte_d  = tx_byte_q;
    idx_inc    = idx_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          shift_d = bus.i_pc;
          phase_d = PH_PC;
          bcnt_d  = '0;
          state_d = S_SEND;
        end
      end
      // The read address was registered on entry to ADDR, so data is valid here.
      S_ADDR: state_d = S_CAPTURE;
      S_CAPTURE: begin
        shift_d = (phase_q == PH_MEM) ? bus.i_mem_data : bus.i_reg_data;
        bcnt_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_byte_d = shift_q[DATA_WIDTH_UART-1:0];
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_tx_done) begin
          shift_d = shift_q >> DATA_WIDTH_UART;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q != LAST_BYTE) begin
            state_d = S_SEND;
          end else begin
            unique case (phase_q)
              PH_PC: begin
                phase_d    = PH_REG;
                idx_d      = '0;
                reg_addr_d = '0;
                state_d    = S_ADDR;
              end
              PH_REG: begin
                state_d = S_ADDR;
                if (idx_inc == REG_END) begin
                  phase_d    = PH_MEM;
                  idx_d      = '0;
                  mem_addr_d = '0;
                end else begin
                  idx_d      = idx_inc;
                  reg_addr_d = idx_inc[ADDR_WIDTH-1:0];
                end
              end
              default: begin
                idx_d = idx_inc;
                if (idx_inc == MEM_END) begin
                  state_d = S_DONE;
                end else begin
                  mem_addr_d = idx_inc[ADDR_WIDTH-1:0];
                  state_d    = S_ADDR;
                end
              end
            endcase
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The byte register keeps o_tx_byte steady through WAIT after the shift moves on.
  assign bus.o_tx_byte   = (state_q == S_SEND) ? shift_q[DATA_WIDTH_UART-1:0] : tx_byte_q;
  assign bus.o_tx_signal = (state_q == S_SEND);
  assign bus.o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.o_dump_done = (state_q == S_DONE);
  assign bus.o_reg_addr  = reg_addr_q;
  assign bus.o_mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: UART/memory environment model plus a byte-stream reference built from PC, regs and mem.
module tb_debug_dump_tx;
  localparam int DW = 32, UW = 8, NR = 32, NM = 32, AW = 5;
  localparam int NBYTES = 4 * (1 + NR + NM);

  logic i_clock = 1'b0;
  logic i_reset;
  always #5 i_clock = ~i_clock;

  debug_dump_tx_if #(.DATA_WIDTH(DW), .DATA_WIDTH_UART(UW), .ADDR_WIDTH(AW)) bus ();

  debug_dump_tx #(
    .DATA_WIDTH(DW), .DATA_WIDTH_UART(UW), .N_REGS(NR), .N_MEM(NM), .ADDR_WIDTH(AW)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Register file / data memory: data follows the address one cycle later, DEADBEEF if it moved.
  logic [DW-1:0] reg_arr [NR];
  logic [DW-1:0] mem_arr [NM];
  logic [AW-1:0] reg_addr_d, mem_addr_d;
  always @(posedge i_clock) begin
    reg_addr_d <= bus.o_reg_addr;
    mem_addr_d <= bus.o_mem_addr;
  end
  assign bus.i_reg_data = (bus.o_reg_addr == reg_addr_d) ? reg_arr[reg_addr_d] : 32'hDEAD_BEEF;
  assign bus.i_mem_data = (bus.o_mem_addr == mem_addr_d) ? mem_arr[mem_addr_d] : 32'hDEAD_BEEF;

  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  logic [7:0] ref2 [$];
  int sig_cyc [$];
  int done_cyc [$];
  int st_cyc [$];
  int cyc = 0, ndone = 0, dd_cyc = 0, pend = -1, spur_left = 0, nbyte = 0;
  int done_delay = 10;
  bit rand_delay = 0, spur_mode = 0, force_done = 0;

  // UART side: logs bytes and answers each tx pulse with a done after a delay.
  initial begin : uart_side
    bit drv;
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge i_clock);
      cyc++;
      if (i_reset) begin
        pend = -1; spur_left = 0; nbyte = 0;
        bus.i_tx_done = force_done;
      end else begin
        drv = force_done;
        if (pend == 0) begin
          drv = 1'b1; pend = -1;
          done_cyc.push_back(cyc);
          nbyte++;
          if (spur_mode && (nbyte % 4 == 0)) spur_left = 2;
        end else if (spur_left > 0) begin
          drv = 1'b1; spur_left--;
        end else if (pend > 0) begin
          pend--;
        end
        if (bus.o_tx_signal) begin
          got.push_back(bus.o_tx_byte);
          sig_cyc.push_back(cyc);
          pend = (rand_delay ? int'($urandom_range(8, 1)) : done_delay) - 1;
        end
        if (bus.i_start && !bus.o_busy && !bus.o_dump_done) st_cyc.push_back(cyc);
        if (bus.o_dump_done) begin
          ndone++; dd_cyc = cyc; nbyte = 0;
        end
        bus.i_tx_done = drv;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected stream: PC, then each register, then each memory word, every word LSB first.
  task automatic build_model(input logic [DW-1:0] pc);
    logic [DW-1:0] words [$];
    exp_q.delete();
    words.push_back(pc);
    for (int k = 0; k < NR; k++) words.push_back(reg_arr[k]);
    for (int k = 0; k < NM; k++) words.push_back(mem_arr[k]);
    foreach (words[w]) for (int b = 0; b < 4; b++) exp_q.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
  endtask

  task automatic load_s2_data();
    for (int k = 0; k < NR; k++) reg_arr[k] = k * 32'h0101_0101;
    for (int k = 0; k < NM; k++) mem_arr[k] = 32'hA500_0000 | k;
  endtask

  task automatic load_random_data();
    for (int k = 0; k < NR; k++) reg_arr[k] = $urandom;
    for (int k = 0; k < NM; k++) mem_arr[k] = $urandom;
  endtask

  int b0, db0, sb0, nd0, n_hold;

  task automatic begin_dump(input logic [DW-1:0] pc);
    @(posedge i_clock); #1;
    b0 = got.size(); db0 = done_cyc.size(); sb0 = st_cyc.size(); nd0 = ndone;
    bus.i_pc = pc; bus.i_start = 1'b1;
    @(posedge i_clock); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_start(input logic [DW-1:0] pc);
    @(posedge i_clock); #1;
    bus.i_pc = pc; bus.i_start = 1'b1;
    @(posedge i_clock); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_dump(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 12000; k++) begin
      @(negedge i_clock);
      if (bus.o_dump_done) begin seen = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic wait_bytes(input string tag, input int b, input int n);
    for (int k = 0; k < 4000; k++) begin
      @(negedge i_clock);
      if (got.size() - b >= n) break;
    end
    chk({tag, "_bytes_reached"}, 64'(got.size() - b >= n), 64'd1);
  endtask

  task automatic check_dump(input string tag, input int b, input int n, input int db, input int sb, input int nd);
    int errs = 0, lat = 0, st_lat = -1, dd_lat = -1;
    chk({tag, "_len"}, 64'(n), 64'(NBYTES));
    for (int i = 0; i < NBYTES; i++) if (i >= n || got[b + i] !== exp_q[i]) errs++;
    chk({tag, "_stream_errs"}, 64'(errs), 64'd0);
    for (int i = 1; i < NBYTES && i < n && (db + i - 1) < done_cyc.size(); i++)
      if (sig_cyc[b + i] - done_cyc[db + i - 1] != ((i % 4 == 0) ? 3 : 1)) lat++;
    chk({tag, "_latency_errs"}, 64'(lat), 64'd0);
    if (st_cyc.size() > sb && n > 0) st_lat = sig_cyc[b] - st_cyc[sb];
    chk({tag, "_start_latency"}, 64'(st_lat), 64'd1);
    if (done_cyc.size() >= db + NBYTES) dd_lat = dd_cyc - done_cyc[db + NBYTES - 1];
    chk({tag, "_dump_done_latency"}, 64'(dd_lat), 64'd1);
    chk({tag, "_dump_done_count"}, 64'(ndone - nd), 64'd1);
  endtask

  initial begin : main
    logic [DW-1:0] pr;
    int errs, ba, dba, sba, nda, nfirst;
    i_reset = 1'b1; bus.i_start = 1'b0; bus.i_pc = '0;
    load_s2_data();
    repeat (3) @(posedge i_clock); #1;
    chk("rst_tx_signal", 64'(bus.o_tx_signal), 64'd0);
    chk("rst_tx_byte",   64'(bus.o_tx_byte),   64'd0);
    chk("rst_busy",      64'(bus.o_busy),      64'd0);
    chk("rst_dump_done", 64'(bus.o_dump_done), 64'd0);
    chk("rst_addrs",     64'({bus.o_reg_addr, bus.o_mem_addr}), 64'd0);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clock); #1;
    chk("idle_busy", 64'(bus.o_busy), 64'd0);

    // Full dump with the directed data set, fixed 10-cycle done delay.
    done_delay = 10;
    begin_dump(32'h0000_0040);
    wait_dump("s2");
    repeat (4) @(negedge i_clock);
    build_model(32'h0000_0040);
    check_dump("s2", b0, got.size() - b0, db0, sb0, nd0);
    chk("s2_pc_word",  64'({got[b0 + 3], got[b0 + 2], got[b0 + 1], got[b0]}), 64'h0000_0040);
    chk("s2_reg3",     64'({got[b0 + 19], got[b0 + 18], got[b0 + 17], got[b0 + 16]}), 64'h0303_0303);
    chk("s2_mem31",    64'({got[b0 + 256], got[b0 + 257], got[b0 + 258], got[b0 + 259]}), 64'h1F00_00A5);
    errs = 0;
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 4; j++) if (got[b0 + 4 + 4 * k + j] !== 8'(k)) errs++;
    chk("s3_reg_addr_sequence", 64'(errs), 64'd0);
    chk("s3_reg_addr_held", 64'(bus.o_reg_addr), 64'd31);
    chk("s3_mem_addr_held", 64'(bus.o_mem_addr), 64'd31);
    for (int i = 0; i < NBYTES; i++) ref2.push_back(got[b0 + i]);

    // Reset in the REG phase, byte 2 of register 5, then restart.
    begin_dump(32'h0000_0040);
    wait_bytes("s1", b0, 27);
    @(posedge i_clock); #2;
    i_reset = 1'b1;
    #1;
    chk("s1_rst_tx_signal", 64'(bus.o_tx_signal), 64'd0);
    chk("s1_rst_tx_byte",   64'(bus.o_tx_byte),   64'd0);
    chk("s1_rst_busy",      64'(bus.o_busy),      64'd0);
    chk("s1_rst_reg_addr",  64'(bus.o_reg_addr),  64'd0);
    chk("s1_rst_mem_addr",  64'(bus.o_mem_addr),  64'd0);
    repeat (2) @(posedge i_clock); #1;
    i_reset = 1'b0;
    n_hold = got.size();
    repeat (5) @(posedge i_clock); #1;
    chk("s1_idle_no_tx", 64'(got.size() - n_hold), 64'd0);
    chk("s1_idle_busy",  64'(bus.o_busy), 64'd0);
    pr = $urandom;
    begin_dump(pr);
    wait_dump("s1");
    repeat (4) @(negedge i_clock);
    build_model(pr);
    check_dump("s1", b0, got.size() - b0, db0, sb0, nd0);
    chk("s1_first_byte", 64'(got[b0]), 64'(pr[7:0]));

    // Start while busy, random data and random done delays.
    load_random_data();
    rand_delay = 1'b1;
    pr = $urandom;
    begin_dump(pr);
    wait_bytes("s4a", b0, 10);
    pulse_start(~pr);
    wait_bytes("s4b", b0, 200);
    pulse_start(pr ^ 32'h5555_5555);
    wait_dump("s4");
    repeat (4) @(negedge i_clock);
    build_model(pr);
    check_dump("s4", b0, got.size() - b0, db0, sb0, nd0);

    // Spurious done pulses in IDLE and during ADDR/CAPTURE.
    load_s2_data();
    rand_delay = 1'b0; done_delay = 3;
    spur_mode = 1'b1;
    n_hold = got.size();
    @(posedge i_clock); #1 force_done = 1'b1;
    repeat (2) @(posedge i_clock); #1 force_done = 1'b0;
    chk("s5_idle_done_no_tx", 64'(got.size() - n_hold), 64'd0);
    begin_dump(32'h0000_0040);
    wait_dump("s5");
    repeat (4) @(negedge i_clock);
    build_model(32'h0000_0040);
    check_dump("s5", b0, got.size() - b0, db0, sb0, nd0);
    errs = 0;
    for (int i = 0; i < NBYTES; i++) if (got[b0 + i] !== ref2[i]) errs++;
    chk("s5_vs_s2_stream", 64'(errs), 64'd0);
    spur_mode = 1'b0;
    repeat (4) @(posedge i_clock);

    // Back-to-back: restart in the cycle after o_dump_done with a new PC.
    load_random_data();
    rand_delay = 1'b1;
    pr = $urandom;
    begin_dump(pr);
    wait_dump("s6a");
    ba = b0; dba = db0; sba = sb0; nda = nd0;
    begin_dump(32'h0000_0004);
    nfirst = b0 - ba;
    repeat (2) @(negedge i_clock);
    build_model(pr);
    check_dump("s6a", ba, nfirst, dba, sba, nda);
    wait_dump("s6b");
    repeat (4) @(negedge i_clock);
    build_model(32'h0000_0004);
    check_dump("s6b", b0, got.size() - b0, db0, sb0, nd0);
    chk("s6b_pc_word", 64'({got[b0 + 3], got[b0 + 2], got[b0 + 1], got[b0]}), 64'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
